// File: rtl/register_file_banked_pkg.sv
// register_file_banked_pkg
//   Shared types and helpers for the banked vector register file.
//   Types reflect the default configuration (4 banks, 8 warps, 32 lanes of
//   32 bits, 64 registers per warp). The helpers take their sizes as
//   arguments so a top with overridden parameters can still use them.
//   Optional feature macro: BGPU_RF_WRITE_BYPASS_EN (used by register_bank).
package register_file_banked_pkg;

    localparam int RF_NUM_BANKS      = 4;
    localparam int RF_NUM_READ_PORTS = 2;
    localparam int RF_NUM_WARPS      = 8;
    localparam int RF_WARP_WIDTH     = 32;
    localparam int RF_REG_WIDTH      = 32;
    localparam int RF_REG_IDX_WIDTH  = 6;
    localparam int RF_BANK_IDX_WIDTH = (RF_NUM_BANKS > 1) ? $clog2(RF_NUM_BANKS) : 1;
    localparam int RF_WID_WIDTH      = (RF_NUM_WARPS > 1) ? $clog2(RF_NUM_WARPS) : 1;

    typedef logic [RF_WID_WIDTH-1:0]                 wid_t;
    typedef logic [RF_REG_IDX_WIDTH-1:0]             reg_idx_t;
    typedef logic [RF_WARP_WIDTH-1:0]                act_mask_t;
    typedef logic [RF_REG_WIDTH*RF_WARP_WIDTH-1:0]   warp_data_t;
    typedef logic [RF_BANK_IDX_WIDTH-1:0]            bank_idx_t;

    // Adding wid skews each warp's registers across banks so that the same
    // register of different warps does not always collide on one bank.
    function automatic int unsigned bank_of(input int unsigned wid,
                                            input int unsigned reg_idx,
                                            input int unsigned num_banks);
        return (wid + reg_idx) % num_banks;
    endfunction

    function automatic int unsigned addr_in_bank(input int unsigned wid,
                                                 input int unsigned reg_idx,
                                                 input int unsigned reg_idx_width,
                                                 input int unsigned bank_shift);
        return (wid << (reg_idx_width - bank_shift)) | (reg_idx >> bank_shift);
    endfunction

endpackage

// File: rtl/register_file_banked_bank.sv
// register_bank
//   One bank of the register file: 1 read + 1 write per cycle, per-lane
//   write enables, registered read data (held when no read is issued).
//   Optional feature macro: BGPU_RF_WRITE_BYPASS_EN -- a read of the address
//   being written in the same cycle returns the newly written lanes;
//   without it the read returns the old contents (read-before-write).
// Ports:
//   i_clk, i_rst           clock, async active-high reset (read data only)
//   i_re, i_raddr          read enable / address
//   o_rdata                read data, valid the cycle after i_re
//   i_we, i_waddr          write enable / address
//   i_wmask, i_wdata       per-lane write enable / write data
module register_bank
    import register_file_banked_pkg::*;
#(
    parameter int AddrWidth = 7,
    parameter int Depth     = 128,
    parameter int WarpWidth = 32,
    parameter int RegWidth  = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_re,
    input  logic [AddrWidth-1:0]          i_raddr,
    output logic [RegWidth*WarpWidth-1:0] o_rdata,
    input  logic                          i_we,
    input  logic [AddrWidth-1:0]          i_waddr,
    input  logic [WarpWidth-1:0]          i_wmask,
    input  logic [RegWidth*WarpWidth-1:0] i_wdata
);

    logic [RegWidth*WarpWidth-1:0] r_mem [Depth];
    logic [RegWidth*WarpWidth-1:0] r_rdata;
    logic [RegWidth*WarpWidth-1:0] w_rd_word;

    always_comb begin
        w_rd_word = r_mem[i_raddr];
`ifdef BGPU_RF_WRITE_BYPASS_EN
        if (i_we && (i_waddr == i_raddr)) begin
            for (int t = 0; t < WarpWidth; t++) begin
                if (i_wmask[t]) begin
                    w_rd_word[t*RegWidth +: RegWidth] = i_wdata[t*RegWidth +: RegWidth];
                end
            end
        end
`endif
    end

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int t = 0; t < WarpWidth; t++) begin
                if (i_wmask[t]) begin
                    r_mem[i_waddr][t*RegWidth +: RegWidth] <= i_wdata[t*RegWidth +: RegWidth];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= w_rd_word;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/register_file_banked.sv
// register_file_banked
//   Banked, per-lane-masked vector register file. Operand-collector read
//   requests are arbitrated per bank (round-robin across read ports); a
//   granted read returns full warp data exactly one cycle later on the same
//   port. Write-back from the execution unit is accepted every cycle.
//   Optional feature macro: BGPU_RF_WRITE_BYPASS_EN (same-cycle write->read
//   bypass inside each bank).
// Ports:
//   clk_i, rst_i                   clock, async active-high reset
//   opc_read_req_valid_i/wid_i/reg_idx_i   per-port read request
//   opc_read_req_ready_o           per-port grant (combinational)
//   opc_read_rsp_valid_o/data_o    per-port response, one cycle after grant
//   eu_wb_valid_i/wid_i/reg_idx_i/act_mask_i/data_i   write-back
//   eu_wb_ready_o                  always 1
module register_file_banked
    import register_file_banked_pkg::*;
#(
    parameter int NumBanks     = RF_NUM_BANKS,
    parameter int NumReadPorts = RF_NUM_READ_PORTS,
    parameter int NumWarps     = RF_NUM_WARPS,
    parameter int WarpWidth    = RF_WARP_WIDTH,
    parameter int RegWidth     = RF_REG_WIDTH,
    parameter int RegIdxWidth  = RF_REG_IDX_WIDTH,
    localparam int BankIdxWidth = (NumBanks > 1) ? $clog2(NumBanks) : 1,
    localparam int WidWidth     = (NumWarps > 1) ? $clog2(NumWarps) : 1,
    localparam int DataWidth    = RegWidth * WarpWidth
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumReadPorts-1:0]             opc_read_req_valid_i,
    input  logic [NumReadPorts*WidWidth-1:0]    opc_read_req_wid_i,
    input  logic [NumReadPorts*RegIdxWidth-1:0] opc_read_req_reg_idx_i,
    output logic [NumReadPorts-1:0]             opc_read_req_ready_o,
    output logic [NumReadPorts-1:0]             opc_read_rsp_valid_o,
    output logic [NumReadPorts*DataWidth-1:0]   opc_read_rsp_data_o,
    input  logic                                eu_wb_valid_i,
    input  logic [WidWidth-1:0]                 eu_wb_wid_i,
    input  logic [RegIdxWidth-1:0]              eu_wb_reg_idx_i,
    input  logic [WarpWidth-1:0]                eu_wb_act_mask_i,
    input  logic [DataWidth-1:0]                eu_wb_data_i,
    output logic                                eu_wb_ready_o
);

    localparam int BankShift = $clog2(NumBanks);
    localparam int AddrWidth = WidWidth + RegIdxWidth - BankShift;
    localparam int Depth     = NumWarps * (2 ** RegIdxWidth) / NumBanks;
    localparam int PtrWidth  = (NumReadPorts > 1) ? $clog2(NumReadPorts) : 1;

    logic [BankIdxWidth-1:0] w_req_bank [NumReadPorts];
    logic [AddrWidth-1:0]    w_req_addr [NumReadPorts];
    logic [BankIdxWidth-1:0] w_wb_bank;
    logic [AddrWidth-1:0]    w_wb_addr;

    logic [NumReadPorts-1:0] w_gnt        [NumBanks];
    logic [PtrWidth-1:0]     w_gnt_idx    [NumBanks];
    logic [NumBanks-1:0]     w_bank_re;
    logic [NumBanks-1:0]     w_bank_we;
    logic [AddrWidth-1:0]    w_bank_raddr [NumBanks];
    logic [DataWidth-1:0]    w_bank_rdata [NumBanks];
    logic [NumReadPorts-1:0] w_ready;

    logic [PtrWidth-1:0]     r_ptr      [NumBanks];
    logic [NumReadPorts-1:0] r_rsp_valid;
    logic [BankIdxWidth-1:0] r_rsp_bank [NumReadPorts];

    always_comb begin
        for (int p = 0; p < NumReadPorts; p++) begin
            w_req_bank[p] = BankIdxWidth'(bank_of(32'(opc_read_req_wid_i[p*WidWidth +: WidWidth]),
                                                  32'(opc_read_req_reg_idx_i[p*RegIdxWidth +: RegIdxWidth]),
                                                  NumBanks));
            w_req_addr[p] = AddrWidth'(addr_in_bank(32'(opc_read_req_wid_i[p*WidWidth +: WidWidth]),
                                                    32'(opc_read_req_reg_idx_i[p*RegIdxWidth +: RegIdxWidth]),
                                                    RegIdxWidth, BankShift));
        end
        w_wb_bank = BankIdxWidth'(bank_of(32'(eu_wb_wid_i), 32'(eu_wb_reg_idx_i), NumBanks));
        w_wb_addr = AddrWidth'(addr_in_bank(32'(eu_wb_wid_i), 32'(eu_wb_reg_idx_i),
                                            RegIdxWidth, BankShift));
    end

    // Round-robin: scan ports starting at the bank's pointer, first requester wins.
    always_comb begin
        for (int b = 0; b < NumBanks; b++) begin
            w_gnt[b]        = '0;
            w_gnt_idx[b]    = '0;
            w_bank_re[b]    = 1'b0;
            w_bank_raddr[b] = '0;
            for (int k = 0; k < NumReadPorts; k++) begin
                automatic int p = (int'(r_ptr[b]) + k) % NumReadPorts;
                if (!w_bank_re[b] && !rst_i && opc_read_req_valid_i[p] &&
                    (w_req_bank[p] == BankIdxWidth'(b))) begin
                    w_gnt[b][p]     = 1'b1;
                    w_gnt_idx[b]    = PtrWidth'(p);
                    w_bank_re[b]    = 1'b1;
                    w_bank_raddr[b] = w_req_addr[p];
                end
            end
        end
    end

    always_comb begin
        w_ready = '0;
        for (int b = 0; b < NumBanks; b++) begin
            w_ready = w_ready | w_gnt[b];
        end
        for (int b = 0; b < NumBanks; b++) begin
            w_bank_we[b] = eu_wb_valid_i && !rst_i && (w_wb_bank == BankIdxWidth'(b));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < NumBanks; b++) begin
                r_ptr[b] <= '0;
            end
            for (int p = 0; p < NumReadPorts; p++) begin
                r_rsp_bank[p] <= '0;
            end
            r_rsp_valid <= '0;
        end else begin
            for (int b = 0; b < NumBanks; b++) begin
                if (w_bank_re[b]) begin
                    r_ptr[b] <= PtrWidth'((int'(w_gnt_idx[b]) + 1) % NumReadPorts);
                end
            end
            for (int p = 0; p < NumReadPorts; p++) begin
                if (w_ready[p]) begin
                    r_rsp_bank[p] <= w_req_bank[p];
                end
            end
            r_rsp_valid <= w_ready;
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        register_bank #(
            .AddrWidth (AddrWidth),
            .Depth     (Depth),
            .WarpWidth (WarpWidth),
            .RegWidth  (RegWidth)
        ) u_bank (
            .i_clk   (clk_i),
            .i_rst   (rst_i),
            .i_re    (w_bank_re[b]),
            .i_raddr (w_bank_raddr[b]),
            .o_rdata (w_bank_rdata[b]),
            .i_we    (w_bank_we[b]),
            .i_waddr (w_wb_addr),
            .i_wmask (eu_wb_act_mask_i),
            .i_wdata (eu_wb_data_i)
        );
    end

    // Data is forced to zero outside a response so nothing stale leaks out.
    always_comb begin
        opc_read_rsp_data_o = '0;
        for (int p = 0; p < NumReadPorts; p++) begin
            if (r_rsp_valid[p]) begin
                opc_read_rsp_data_o[p*DataWidth +: DataWidth] = w_bank_rdata[r_rsp_bank[p]];
            end
        end
    end

    assign opc_read_req_ready_o = w_ready;
    assign opc_read_rsp_valid_o = r_rsp_valid;
    assign eu_wb_ready_o        = 1'b1;

endmodule

// File: tb/tb_register_file_banked.sv
module tb_register_file_banked;
    import register_file_banked_pkg::*;

    localparam int NP = 2;
    localparam int NB = 4;
    localparam int NW = 8;
    localparam int NR = 64;
    localparam int WW = 32;
    localparam int RW = 32;
    localparam int DW = WW * RW;

    logic              clk;
    logic              rst;
    logic [NP-1:0]     req_valid;
    logic [NP*3-1:0]   req_wid;
    logic [NP*6-1:0]   req_reg;
    logic [NP-1:0]     req_ready;
    logic [NP-1:0]     rsp_valid;
    logic [NP*DW-1:0]  rsp_data;
    logic              wb_valid;
    logic [2:0]        wb_wid;
    logic [5:0]        wb_reg;
    logic [WW-1:0]     wb_mask;
    logic [DW-1:0]     wb_data;
    logic              wb_ready;

    register_file_banked dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .opc_read_req_valid_i   (req_valid),
        .opc_read_req_wid_i     (req_wid),
        .opc_read_req_reg_idx_i (req_reg),
        .opc_read_req_ready_o   (req_ready),
        .opc_read_rsp_valid_o   (rsp_valid),
        .opc_read_rsp_data_o    (rsp_data),
        .eu_wb_valid_i          (wb_valid),
        .eu_wb_wid_i            (wb_wid),
        .eu_wb_reg_idx_i        (wb_reg),
        .eu_wb_act_mask_i       (wb_mask),
        .eu_wb_data_i           (wb_data),
        .eu_wb_ready_o          (wb_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model: plain array of lane values, per-bank next-priority port
    logic [31:0] mdl [NW][NR][WW];
    int          mptr [NB];
    bit          exp_vld [NP];
    logic [31:0] exp_lane [NP][WW];
    bit          gnt_m [NP];

    // stimulus state
    bit          rv [NP];
    int          rwid [NP];
    int          rreg [NP];
    bit          wv;
    int          wwid, wreg;
    logic [31:0] wmask;
    logic [31:0] wlane [WW];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            req_valid[p]         = rv[p];
            req_wid[p*3 +: 3]    = 3'(rwid[p]);
            req_reg[p*6 +: 6]    = 6'(rreg[p]);
        end
        wb_valid = wv;
        wb_wid   = 3'(wwid);
        wb_reg   = 6'(wreg);
        wb_mask  = wmask;
        for (int t = 0; t < WW; t++) wb_data[t*RW +: RW] = wlane[t];
    endtask

    // One clock cycle: inputs applied after negedge, outputs checked, model advanced at posedge.
    task automatic cycle();
        drive();
        #1;
        if (rst) begin
            for (int p = 0; p < NP; p++) exp_vld[p] = 0;
            for (int b = 0; b < NB; b++) mptr[b] = 0;
        end
        for (int p = 0; p < NP; p++) gnt_m[p] = 0;
        if (!rst) begin
            for (int b = 0; b < NB; b++) begin
                automatic bit done = 0;
                for (int k = 0; k < NP; k++) begin
                    automatic int p = (mptr[b] + k) % NP;
                    if (!done && rv[p] && ((rwid[p] + rreg[p]) % NB == b)) begin
                        gnt_m[p] = 1;
                        done = 1;
                    end
                end
            end
        end
        chk("wb_ready", 64'(wb_ready), 64'd1);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("ready%0d", p), 64'(req_ready[p]), 64'(gnt_m[p]));
            chk($sformatf("rsp_valid%0d", p), 64'(rsp_valid[p]), 64'(exp_vld[p]));
            if (exp_vld[p]) begin
                for (int t = 0; t < WW; t++) begin
                    chk($sformatf("rsp%0d_lane%0d", p, t),
                        64'(rsp_data[p*DW + t*RW +: RW]), 64'(exp_lane[p][t]));
                end
            end
        end
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            exp_vld[p] = gnt_m[p];
            if (gnt_m[p]) begin
                for (int t = 0; t < WW; t++) begin
                    exp_lane[p][t] = mdl[rwid[p]][rreg[p]][t];
`ifdef BGPU_RF_WRITE_BYPASS_EN
                    if (wv && !rst && wwid == rwid[p] && wreg == rreg[p] && wmask[t])
                        exp_lane[p][t] = wlane[t];
`endif
                end
                mptr[(rwid[p] + rreg[p]) % NB] = (p + 1) % NP;
            end
        end
        if (wv && !rst) begin
            for (int t = 0; t < WW; t++) if (wmask[t]) mdl[wwid][wreg][t] = wlane[t];
        end
        @(negedge clk);
    endtask

    task automatic set_write(input int w, input int r, input logic [31:0] m, input logic [31:0] val);
        wv = 1; wwid = w; wreg = r; wmask = m;
        for (int t = 0; t < WW; t++) wlane[t] = val;
    endtask

    task automatic idle();
        wv = 0; wmask = '0;
        for (int p = 0; p < NP; p++) rv[p] = 0;
    endtask

    initial begin
        rst = 1'b1;
        for (int p = 0; p < NP; p++) begin rv[p] = 0; rwid[p] = 0; rreg[p] = 0; exp_vld[p] = 0; end
        for (int b = 0; b < NB; b++) mptr[b] = 0;
        wv = 0; wwid = 0; wreg = 0; wmask = '0;
        for (int t = 0; t < WW; t++) wlane[t] = '0;

        // reset state
        repeat (2) cycle();
        drive();
        #1;
        chk("rst_data_zero", 64'(rsp_data == '0), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // fill every register so later reads have defined data
        for (int w = 0; w < NW; w++) begin
            for (int r = 0; r < NR; r++) begin
                wv = 1; wwid = w; wreg = r; wmask = '1;
                for (int t = 0; t < WW; t++) wlane[t] = $urandom;
                cycle();
            end
        end
        idle();

        // basic write then read
        set_write(1, 3, 32'hFFFF_FFFF, 32'hA5A5_A5A5); cycle(); idle();
        rv[0] = 1; rwid[0] = 1; rreg[0] = 3; cycle(); idle(); cycle();

        // both ports on one bank: alternating grants
        for (int i = 0; i < 3; i++) begin
            rv[0] = 1; rwid[0] = 0; rreg[0] = 4;
            rv[1] = !gnt_m[1] || i == 0; rwid[1] = 0; rreg[1] = 4;
            cycle();
        end
        idle(); cycle(); cycle();

        // different banks: both granted together
        rv[0] = 1; rwid[0] = 0; rreg[0] = 1;
        rv[1] = 1; rwid[1] = 0; rreg[1] = 2;
        cycle(); chk("dual_grant", {62'd0, gnt_m[1], gnt_m[0]}, 64'd3);
        idle(); cycle();

        // partial-lane write
        set_write(3, 7, 32'hFFFF_FFFF, 32'h2222_2222); cycle();
        set_write(3, 7, 32'h0000_FFFF, 32'h1111_1111); cycle(); idle();
        rv[0] = 1; rwid[0] = 3; rreg[0] = 7; cycle(); idle(); cycle();

        // same-cycle write and read of one register
        set_write(2, 5, 32'hFFFF_FFFF, 32'h3333_3333);
        rv[1] = 1; rwid[1] = 2; rreg[1] = 5; cycle(); idle(); cycle();

        // reset right after a grant drops the response and restarts priority
        rv[0] = 1; rwid[0] = 0; rreg[0] = 4; cycle(); idle();
        rst = 1'b1; cycle(); rst = 1'b0;
        rv[0] = 1; rwid[0] = 0; rreg[0] = 8;
        rv[1] = 1; rwid[1] = 0; rreg[1] = 8;
        cycle(); chk("rr_after_rst", {62'd0, gnt_m[1], gnt_m[0]}, 64'd1);
        rv[0] = 0; cycle(); idle(); cycle();

        // randomized traffic; requests held until granted
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < NP; p++) begin
                if (!rv[p] && $urandom_range(0, 9) < 7) begin
                    rv[p] = 1;
                    rwid[p] = $urandom_range(0, NW - 1);
                    rreg[p] = $urandom_range(0, NR - 1);
                end
            end
            wv = ($urandom_range(0, 1) == 1);
            wwid = $urandom_range(0, NW - 1);
            wreg = $urandom_range(0, NR - 1);
            if (rv[0] && $urandom_range(0, 3) == 0) begin wwid = rwid[0]; wreg = rreg[0]; end
            case ($urandom_range(0, 3))
                0:       wmask = '0;
                1:       wmask = '1;
                default: wmask = $urandom;
            endcase
            for (int t = 0; t < WW; t++) wlane[t] = $urandom;
            rst = ($urandom_range(0, 199) == 0);
            cycle();
            rst = 1'b0;
            for (int p = 0; p < NP; p++) if (gnt_m[p]) rv[p] = 0;
        end
        idle(); cycle(); cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
